fpmul_arb: RTL

Round-robin arbiter and sequencer that shares one floating-point multiplier (fpmul datapath plus control unit) among N_REQ requesters. It accepts one operand pair at a time and pulses the multiplier's Start. It captures the packaged product and exception flags on Done and returns them on a single tagged response channel. It also enforces the multiplier's recovery gap and a watchdog timeout.

---
 rtl/fpmul_arb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fpmul_arb.sv
// Round-robin front end for one shared fpmul: grants one requester at a time,
// sequences Start/Done with a recovery gap and watchdog, returns a tagged response.
module fpmul_arb #(
  parameter int N_REQ    = 4,
  parameter int IDLE_GAP = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0][31:0]         req_a,
  input  logic [N_REQ-1:0][31:0]         req_b,
  output logic [31:0]                    mul_a,
  output logic [31:0]                    mul_b,
  output logic                           mul_start,
  input  logic                           mul_done,
  input  logic [31:0]                    mul_p,
  input  logic [4:0]                     mul_flags,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(N_REQ)-1:0]       rsp_id,
  output logic [31:0]                    rsp_p,
  output logic [4:0]                     rsp_flags,
  output logic                           rsp_err
  ,output logic                          busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(IDLE_GAP + 1);

  typedef enum logic [2:0] {S_GAP, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [GW-1:0]   gap_q;
  logic [TW-1:0]   tmr_q;
  logic [IW-1:0]   ptr_q, ptr_d, id_q, win;
  logic [31:0]     a_q, b_q, p_q;
  logic [4:0]      fl_q;
  logic            err_q, found;
  logic [IW:0]     sum;

  // Search ptr, ptr+1, ... wrapping; first valid requester wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (!found && req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  assign ptr_d     = (id_q == IW'(N_REQ-1)) ? '0 : id_q + 1'b1;
  assign req_ready = (state_q == S_IDLE && found) ? (N_REQ'(1) << win) : '0;
  assign mul_start = (state_q == S_ISSUE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_id    = id_q;
  assign rsp_p     = p_q;
  assign rsp_flags = fl_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_GAP;
      gap_q   <= '0;
      tmr_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      fl_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_GAP: begin
          gap_q <= gap_q + 1'b1;
          if (gap_q == GW'(IDLE_GAP-1)) state_q <= S_IDLE;
        end
        S_IDLE: if (found) begin
          id_q    <= win;
          a_q     <= req_a[win];
          b_q     <= req_b[win];
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          tmr_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          tmr_q <= tmr_q + 1'b1;
          // Done takes priority over a simultaneous watchdog expiry.
          if (mul_done) begin
            p_q     <= mul_p;
            fl_q    <= mul_flags;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (tmr_q == TW'(TIMEOUT-2)) begin
            p_q     <= 32'h7FC0_0000;
            fl_q    <= 5'b01000;
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_RESP: if (rsp_ready) begin
          ptr_q   <= ptr_d;
          gap_q   <= '0;
          state_q <= S_GAP;
        end
        default: state_q <= S_GAP;
      endcase
    end
  end
endmodule
